// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART result path.
//   PACE_CYCLES_DEFAULT - default clk cycles per transmitted frame (clk/baud x frame bits).
//   out_state_t         - output-stage state of paced_tx_fifo.
package uart_pkg;

  localparam int unsigned PACE_CYCLES_DEFAULT = 26100;

  typedef enum logic [0:0] {
    IDLE,
    PRESENT
  } out_state_t;

endpackage

// File: rtl/pace_timer.sv
// pace_timer: minimum-spacing timer between output handshakes.
//   clk     - system clock, rising edge.
//   rst     - synchronous active-high clear; leaves the timer expired so the first
//             entry after a clear is not delayed.
//   restart - zero the count (asserted on an output handshake).
//   pace_ok - spacing satisfied (always 1 when PACE_EN is 0).
module pace_timer
  import uart_pkg::*;
#(
  parameter int unsigned PACE_CYCLES = PACE_CYCLES_DEFAULT,
  parameter bit          PACE_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic pace_ok
);

  // At least one bit so PACE_CYCLES == 1 still elaborates.
  localparam int unsigned   CW      = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PACE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count up and saturate at CNT_MAX; restart takes priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_MAX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pace_ok = (cnt_q == CNT_MAX) || !PACE_EN;

endmodule

// File: rtl/paced_tx_fifo.sv
// paced_tx_fifo: byte FIFO between the counter block and the UART transmitter. Entries
// are released no faster than one per PACE_CYCLES through a valid/ready output register.
//   clk         - system clock, rising edge.
//   rst         - synchronous active-high reset.
//   flush       - synchronous clear of contents and status (same effect as rst).
//   wr_en       - write strobe; wr_data - write data.
//   full        - DEPTH entries held in memory.
//   almost_full - level >= AFULL_TH.
//   overflow    - sticky; a write arrived while full (cleared by rst/flush only).
//   level       - entries in memory, excluding the one in the output register.
//   out_valid   - out_data holds an entry; out_ready - transmitter accepts it.
module paced_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned PACE_CYCLES = PACE_CYCLES_DEFAULT,
  parameter bit          PACE_EN     = 1'b1,
  parameter int unsigned AFULL_TH    = DEPTH - 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   LW       = AW + 1;
  localparam logic [LW-1:0] AFULL_LV = LW'(AFULL_TH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  out_state_t        state_q, state_d;

  logic clear;
  logic empty;
  logic full_int;
  logic wr_accept;
  logic load;
  logic handshake;
  logic pace_ok;

  assign clear = rst || flush;

  // Extra pointer MSB distinguishes full from empty when the indexes coincide.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full_int = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // full is taken from registered pointers, so a same-cycle pop cannot admit a write.
  assign wr_accept = wr_en && !full_int;
  assign load      = (state_q == IDLE) && !empty && pace_ok;
  assign handshake = (state_q == PRESENT) && out_ready;

  pace_timer #(
    .PACE_CYCLES (PACE_CYCLES),
    .PACE_EN     (PACE_EN)
  ) u_pace_timer (
    .clk     (clk),
    .rst     (clear),
    .restart (handshake),
    .pace_ok (pace_ok)
  );

  // Output FSM and datapath next-state.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    rd_ptr_d   = rd_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          out_data_d = mem[rd_ptr_q[AW-1:0]];
          rd_ptr_d   = rd_ptr_q + 1'b1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    level_d    = level_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (wr_en && full_int) begin
      overflow_d = 1'b1;
    end
    // A write and a load in the same cycle cancel out.
    unique case ({wr_accept, load})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
      state_q    <= state_d;
    end
  end

  // Storage is not cleared; a write coinciding with a clear is dropped.
  always_ff @(posedge clk) begin
    if (wr_accept && !clear) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign full        = full_int;
  assign almost_full = (level_q >= AFULL_LV);
  assign overflow    = overflow_q;
  assign level       = level_q;
  assign out_valid   = (state_q == PRESENT);
  assign out_data    = out_data_q;

endmodule

// File: tb/tb_paced_tx_fifo.sv
module tb_paced_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // dut_a: DEPTH 8, paced at 10 cycles. dut_b: DEPTH 8, pacing bypassed.
  logic       a_rst = 1'b0, a_flush = 1'b0, a_wr_en = 1'b0, a_ready = 1'b0;
  logic [7:0] a_wr_data = '0, a_data;
  logic       a_full, a_afull, a_ovf, a_valid;
  logic [3:0] a_level;

  logic       b_rst = 1'b0, b_flush = 1'b0, b_wr_en = 1'b0, b_ready = 1'b0;
  logic [7:0] b_wr_data = '0, b_data;
  logic       b_full, b_afull, b_ovf, b_valid;
  logic [3:0] b_level;

  paced_tx_fifo #(
    .DATA_W (8), .DEPTH (8), .PACE_CYCLES (10), .PACE_EN (1'b1)
  ) dut_a (
    .clk (clk), .rst (a_rst), .flush (a_flush), .wr_en (a_wr_en), .wr_data (a_wr_data),
    .full (a_full), .almost_full (a_afull), .overflow (a_ovf), .level (a_level),
    .out_valid (a_valid), .out_data (a_data), .out_ready (a_ready)
  );

  paced_tx_fifo #(
    .DATA_W (8), .DEPTH (8), .PACE_CYCLES (10), .PACE_EN (1'b0)
  ) dut_b (
    .clk (clk), .rst (b_rst), .flush (b_flush), .wr_en (b_wr_en), .wr_data (b_wr_data),
    .full (b_full), .almost_full (b_afull), .overflow (b_ovf), .level (b_level),
    .out_valid (b_valid), .out_data (b_data), .out_ready (b_ready)
  );

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    step(); step();
    n_vec++; if (a_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", a_full); end
    n_vec++; if (a_afull !== 1'b0) begin n_bad++; $display("FAIL reset_afull got %b want 0", a_afull); end
    n_vec++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
    n_vec++; if (a_level !== 4'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", a_level); end
    n_vec++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", a_valid); end
    n_vec++; if (a_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", a_data); end
    n_vec++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_valid got %b want 0", b_valid); end
    n_vec++; if (b_level !== 4'd0) begin n_bad++; $display("FAIL reset_b_level got %0d want 0", b_level); end
    a_rst = 1'b0; b_rst = 1'b0;
  endtask

  // Write in cycle N -> out_valid in N+2, handshake in the same cycle.
  task automatic test_latency();
    a_wr_en = 1'b1; a_wr_data = 8'hA5; a_ready = 1'b1;
    step();
    a_wr_en = 1'b0;
    n_vec++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL lat_n1_valid got %b want 0", a_valid); end
    step();
    n_vec++; if (a_valid !== 1'b1) begin n_bad++; $display("FAIL lat_n2_valid got %b want 1", a_valid); end
    n_vec++; if (a_data !== 8'hA5) begin n_bad++; $display("FAIL lat_n2_data got %h want a5", a_data); end
    step();
    n_vec++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL lat_n3_valid got %b want 0", a_valid); end
  endtask

  task automatic test_pacing();
    int hs_cyc[$];
    logic [7:0] hs_dat[$];
    for (int i = 0; i < 60; i++) begin
      if (a_valid && a_ready) begin hs_cyc.push_back(i); hs_dat.push_back(a_data); end
      a_wr_en   = (i < 3);
      a_wr_data = 8'(i + 1);
      step();
    end
    a_wr_en = 1'b0;
    n_vec++;
    if (hs_cyc.size() != 3) begin
      n_bad++; $display("FAIL pace_count got %0d want 3", hs_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (hs_dat[k] !== 8'(k + 1)) begin
          n_bad++; $display("FAIL pace_data[%0d] got %h want %h", k, hs_dat[k], 8'(k + 1));
        end
      end
      for (int k = 1; k < 3; k++) begin
        n_vec++;
        if (hs_cyc[k] - hs_cyc[k-1] != 11) begin
          n_bad++; $display("FAIL pace_gap[%0d] got %0d want 11", k, hs_cyc[k] - hs_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got[$];
    a_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        n_vec++; if (a_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got %b want 1", a_full); end
        n_vec++; if (a_afull !== 1'b1) begin n_bad++; $display("FAIL ovf_afull got %b want 1", a_afull); end
        n_vec++; if (a_level !== 4'd8) begin n_bad++; $display("FAIL ovf_level got %0d want 8", a_level); end
        n_vec++; if (a_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got %b want 1", a_valid); end
        n_vec++; if (a_data !== 8'h10) begin n_bad++; $display("FAIL ovf_data got %h want 10", a_data); end
        n_vec++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early got %b want 0", a_ovf); end
      end
      a_wr_en = 1'b1; a_wr_data = 8'(8'h10 + i);
      step();
    end
    a_wr_en = 1'b0;
    n_vec++; if (a_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", a_ovf); end
    n_vec++; if (a_level !== 4'd8) begin n_bad++; $display("FAIL ovf_level_after got %0d want 8", a_level); end
    a_ready = 1'b1;
    for (int i = 0; i < 130; i++) begin
      if (a_valid) got.push_back(a_data);
      step();
    end
    n_vec++;
    if (got.size() != 9) begin
      n_bad++; $display("FAIL drain_count got %0d want 9", got.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        n_vec++;
        if (got[k] !== 8'(8'h10 + k)) begin
          n_bad++; $display("FAIL drain_data[%0d] got %h want %h", k, got[k], 8'(8'h10 + k));
        end
      end
    end
    n_vec++; if (a_level !== 4'd0) begin n_bad++; $display("FAIL drain_level got %0d want 0", a_level); end
    n_vec++; if (a_ovf !== 1'b1) begin n_bad++; $display("FAIL drain_ovf got %b want 1", a_ovf); end
  endtask

  task automatic test_hold();
    a_ready = 1'b0;
    a_wr_en = 1'b1; a_wr_data = 8'h55;
    step();
    a_wr_data = 8'h56;
    step();
    a_wr_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      n_vec++;
      if (a_valid !== 1'b1 || a_data !== 8'h55 || a_level !== 4'd1) begin
        n_bad++;
        $display("FAIL hold[%0d] got valid=%b data=%h level=%0d want 1/55/1", i, a_valid, a_data,
                 a_level);
      end
      step();
    end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    n_vec++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release got %b want 0", a_valid); end
    n_vec++; if (a_level !== 4'd1) begin n_bad++; $display("FAIL hold_level got %0d want 1", a_level); end
  endtask

  task automatic test_flush();
    int w;
    for (int i = 0; i < 5; i++) begin
      a_wr_en = 1'b1; a_wr_data = 8'(8'h60 + i);
      step();
    end
    a_wr_en = 1'b0;
    w = 0;
    while (!a_valid && w < 40) begin step(); w++; end
    n_vec++; if (a_valid !== 1'b1) begin n_bad++; $display("FAIL flush_wait got %b want 1", a_valid); end
    n_vec++; if (a_data !== 8'h56) begin n_bad++; $display("FAIL flush_pre_data got %h want 56", a_data); end
    n_vec++; if (a_level !== 4'd5) begin n_bad++; $display("FAIL flush_pre_level got %0d want 5", a_level); end
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    n_vec++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", a_valid); end
    n_vec++; if (a_level !== 4'd0) begin n_bad++; $display("FAIL flush_level got %0d want 0", a_level); end
    n_vec++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL flush_ovf got %b want 0", a_ovf); end
    n_vec++; if (a_full !== 1'b0) begin n_bad++; $display("FAIL flush_full got %b want 0", a_full); end
    a_wr_en = 1'b1; a_wr_data = 8'h7E; a_ready = 1'b1;
    step();
    a_wr_en = 1'b0;
    n_vec++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL flush_n1_valid got %b want 0", a_valid); end
    step();
    n_vec++; if (a_valid !== 1'b1) begin n_bad++; $display("FAIL flush_n2_valid got %b want 1", a_valid); end
    n_vec++; if (a_data !== 8'h7E) begin n_bad++; $display("FAIL flush_n2_data got %h want 7e", a_data); end
    step();
    a_ready = 1'b0;
  endtask

  task automatic test_no_pace();
    int hs_cyc[$];
    logic [7:0] hs_dat[$];
    b_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (b_valid && b_ready) begin hs_cyc.push_back(i); hs_dat.push_back(b_data); end
      n_vec++;
      if (b_level > 4'd2) begin n_bad++; $display("FAIL nopace_level[%0d] got %0d want <=2", i, b_level); end
      b_wr_en   = (i < 32) && (i % 2 == 0);
      b_wr_data = 8'(i / 2);
      step();
    end
    b_wr_en = 1'b0;
    n_vec++;
    if (hs_cyc.size() != 16) begin
      n_bad++; $display("FAIL nopace_count got %0d want 16", hs_cyc.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_vec++;
        if (hs_dat[k] !== 8'(k)) begin
          n_bad++; $display("FAIL nopace_data[%0d] got %h want %h", k, hs_dat[k], 8'(k));
        end
        if (k > 0) begin
          n_vec++;
          if (hs_cyc[k] - hs_cyc[k-1] != 2) begin
            n_bad++; $display("FAIL nopace_gap[%0d] got %0d want 2", k, hs_cyc[k] - hs_cyc[k-1]);
          end
        end
      end
    end
  endtask

  // Write and load together at level DEPTH-1: level stays 7 and full stays low.
  task automatic test_simul_boundary();
    b_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_wr_en = 1'b1; b_wr_data = 8'(8'h80 + i);
      step();
    end
    b_wr_en = 1'b0;
    n_vec++; if (b_level !== 4'd7) begin n_bad++; $display("FAIL simul_pre_level got %0d want 7", b_level); end
    n_vec++; if (b_valid !== 1'b1) begin n_bad++; $display("FAIL simul_pre_valid got %b want 1", b_valid); end
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    b_wr_en = 1'b1; b_wr_data = 8'h88;
    step();
    b_wr_en = 1'b0;
    n_vec++; if (b_level !== 4'd7) begin n_bad++; $display("FAIL simul_level got %0d want 7", b_level); end
    n_vec++; if (b_full !== 1'b0) begin n_bad++; $display("FAIL simul_full got %b want 0", b_full); end
    n_vec++; if (b_valid !== 1'b1) begin n_bad++; $display("FAIL simul_valid got %b want 1", b_valid); end
    n_vec++; if (b_data !== 8'h81) begin n_bad++; $display("FAIL simul_data got %h want 81", b_data); end
  endtask

  initial begin
    #1;
    test_reset();
    test_latency();
    test_pacing();
    test_overflow();
    test_hold();
    test_flush();
    test_no_pace();
    test_simul_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/paced_tx_fifo.md
# paced_tx_fifo

Parametrised byte FIFO that buffers result data (miss-rate samples from the counter block) and releases one entry per pacing interval toward the UART transmitter. It replaces the fixed 8-bit / fixed-interval TX buffer. It adds configurable width, depth and pacing, full/almost-full/overflow status, a fill level, a flush, and a valid/ready output handshake so the transmitter can back-pressure.

## Interface
- DATA_W, 8: entry width in bits.
- DEPTH, 64: number of entries; power of two, ≥ 4.
- PACE_CYCLES, 26100: minimum clk cycles between successive output handshakes (clk/baud × frame length); ≥ 1.
- PACE_EN, 1: 1 = pacing enforced; 0 = pacing bypassed, output limited only by out_ready.
- AFULL_TH, DEPTH-4: level at or above which almost_full asserts.
- clk  in  1  single system clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents and status; reset semantics minus parameters.
- wr_en  in  1  write strobe from the counter block.
- wr_data  in  DATA_W  write data.
- full  out  1  DEPTH entries stored.
- almost_full  out  1  level ≥ AFULL_TH.
- overflow  out  1  sticky: a write arrived while full.
- level  out  $clog2(DEPTH)+1  entries in memory (excludes the entry in the output register).
- out_valid  out  1  out_data holds an entry for the UART.
- out_data  out  DATA_W  entry being offered.
- out_ready  in  1  UART accepts out_data this cycle.

## Operation
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits and wrap naturally. empty = pointers equal; full = indexes equal and MSBs differ.
- Write: wr_en && !full stores wr_data at wr_ptr and increments it. wr_en && full drops data and sets overflow. A same-cycle pop does not unblock the write, because full is evaluated on registered state.
- overflow clears only on rst or flush.
- Output FSM:
  - IDLE: when !empty && pace_ok, load out_data ← mem[rd_ptr], increment rd_ptr, go to PRESENT.
  - PRESENT: out_valid=1; out_data stable. On out_ready, go to IDLE and zero the pace counter.
- Pace counter: counts up, saturates at PACE_CYCLES-1. pace_ok = (cnt == PACE_CYCLES-1) || !PACE_EN.
- level: +1 on an accepted write, -1 on an IDLE load, unchanged when both occur in the same cycle.
- rst and flush: pointers 0, level 0, overflow 0, state IDLE, out_valid 0, cnt = PACE_CYCLES-1 (the first entry is not delayed). Memory contents are not cleared. flush with rst or wr_en in the same cycle: clear wins and the write is dropped.
- Reset mid-PRESENT: the offered entry is discarded with no handshake.

## Timing
- Reset values: full 0, almost_full 0, overflow 0, level 0, out_valid 0, out_data 0.
- Write in cycle N to an empty FIFO with pacer expired: out_valid first high in cycle N+2.
- Handshake in cycle H: out_valid low in H+1. The next out_valid is high no earlier than H+PACE_CYCLES+1; with PACE_EN=0, no earlier than H+2.
- full, almost_full, level and overflow are registered and update the cycle after the causing event.
- out_data changes only on an IDLE→PRESENT transition.
- Simultaneous write and load at level DEPTH-1 leaves level at DEPTH-1 and full low.

## Structure
- Shared package uart_pkg:
  - default PACE_CYCLES constant.
  - out_state_t enum {IDLE, PRESENT}.
- One sub-module, pace_timer (params PACE_CYCLES, PACE_EN; ports clk, rst, restart, pace_ok), instantiated once. The memory is an inferred register array in the top module.

## Test plan
- Reset, then check all outputs at reset values. Write 0xA5 in cycle N with out_ready held 1 → out_valid high in N+2 with out_data=0xA5; handshake completes the same cycle.
- PACE_CYCLES=10, write 0x01,0x02,0x03 back-to-back, out_ready=1 → outputs in order, handshakes exactly 11 cycles apart.
- DEPTH=8, out_ready=0, 10 writes (0x10..0x19):
  - after the 9th write: full=1, level=8, out_valid=1 with 0x10.
  - after the 10th write: overflow=1.
  - then out_ready=1 → 0x10..0x18 drained in order; 0x19 never appears.
- Hold out_ready=0 for 50 cycles during PRESENT → out_data stable and no pointer movement. Raising out_ready → a single handshake.
- Fill 5 entries, assert flush mid-PRESENT → next cycle out_valid=0, level=0, overflow=0. A subsequent write of 0x7E emerges 2 cycles later.
- PACE_EN=0, write 0x00..0x0F continuously with out_ready=1 → one handshake every 2 cycles, values in order, level ≤ 2.
